branch_resolve_ctrl: RTL and testbench

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/riscv_branch_pkg.sv | 13 +
 rtl/zero_detect.sv | 9 +
 rtl/branch_resolve_ctrl.sv | 96 +++++++++
 tb/tb_branch_resolve_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// riscv_branch_pkg: RV32I branch funct3 encodings, resolver FSM states and funct3 legality helper.
package riscv_branch_pkg;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   typedef enum logic [1:0] {IDLE, EVAL, FLUSH} br_state_t;
   function automatic logic is_illegal_f3(input logic [2:0] f3);
      return f3[2:1] == 2'b01;
   endfunction
endpackage

// File: rtl/zero_detect.sv
// zero_detect: flags an all-zero W-bit vector.
module zero_detect #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   output logic         z
);
   assign z = ~|a;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves RV32I conditional branches, emits redirect/flush/illegal pulses.
// Optional saturating statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_funct3,
   input  logic [XLEN-1:0] br_rs1,
   input  logic [XLEN-1:0] br_rs2,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_imm,
   input  logic            stall_in,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            illegal_br,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_taken
);
   import riscv_branch_pkg::*;
   // The redirect cycle already counts as the first flush cycle, so FLUSH holds one fewer.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   br_state_t       state;
   logic [2:0]      f3_q, cnt;
   logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
   logic [XLEN:0]   diff;
   logic            z, borrow, lt, taken, exit_eval;
   assign diff   = {1'b0, rs1_q} - {1'b0, rs2_q};
   assign borrow = diff[XLEN];
   // Signed less-than: differing signs decide directly, otherwise the unsigned borrow does.
   assign lt     = (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) ? rs1_q[XLEN-1] : borrow;
   zero_detect #(.W(XLEN)) u_zero_detect (.a(diff[XLEN-1:0]), .z(z));
   always_comb begin
      taken = f3_q == F3_BEQ  ? z       :
              f3_q == F3_BNE  ? !z      :
              f3_q == F3_BLT  ? lt      :
              f3_q == F3_BGE  ? !lt     :
              f3_q == F3_BLTU ? borrow  :
              f3_q == F3_BGEU ? !borrow : 1'b0;
   end
   assign br_ready       = state == IDLE && !stall_in;
   assign exit_eval      = state == EVAL && !stall_in && !rst;
   assign redirect_valid = exit_eval && taken;
   assign illegal_br     = exit_eval && is_illegal_f3(f3_q);
   assign flush          = state == FLUSH || redirect_valid;
   assign redirect_pc    = pc_q + imm_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         f3_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         pc_q  <= '0;
         imm_q <= '0;
      end else if (!stall_in) begin
         case (state)
            IDLE: if (br_valid) begin
               f3_q  <= br_funct3;
               rs1_q <= br_rs1;
               rs2_q <= br_rs2;
               pc_q  <= br_pc;
               imm_q <= br_imm;
               state <= EVAL;
            end
            EVAL: begin
               cnt   <= FLUSH_LOAD;
               state <= (taken && FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end
            FLUSH: begin
               cnt <= cnt - 3'd1;
               if (cnt <= 3'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches <= '0;
         stat_taken    <= '0;
      end else begin
         if (exit_eval && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
         if (redirect_valid && stat_taken != '1) stat_taken <= stat_taken + 32'd1;
      end
   end
`else
   assign stat_branches = '0;
   assign stat_taken    = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks of branch_resolve_ctrl against a
// transaction-level reference; statistics expectations follow BRANCH_STATS_EN.
module tb_branch_resolve_ctrl;
   localparam int XLEN = 32;
   localparam int FC   = 2;
   logic            clk = 1'b0;
   logic            rst, br_valid, br_ready, stall_in;
   logic [2:0]      br_funct3;
   logic [XLEN-1:0] br_rs1, br_rs2, br_pc, br_imm, redirect_pc;
   logic            redirect_valid, flush, illegal_br;
   logic [31:0]     stat_branches, stat_taken;
   int              checks = 0, errors = 0;
   logic [31:0]     m_br = 0, m_tk = 0;
   branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
      .br_rs1(br_rs1), .br_rs2(br_rs2), .br_pc(br_pc), .br_imm(br_imm), .stall_in(stall_in),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .illegal_br(illegal_br), .stat_branches(stat_branches), .stat_taken(stat_taken)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction
   task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
      check({tag, "_stat_branches"}, stat_branches, m_br);
      check({tag, "_stat_taken"}, stat_taken, m_tk);
`else
      check({tag, "_stat_branches"}, stat_branches, 0);
      check({tag, "_stat_taken"}, stat_taken, 0);
`endif
   endtask
   task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm);
      br_valid = 1; br_funct3 = f3; br_rs1 = a; br_rs2 = b; br_pc = pc; br_imm = imm;
   endtask
   task automatic scramble_inputs();
      br_valid = 1'($urandom_range(0, 1)); br_funct3 = 3'($urandom_range(0, 7));
      br_rs1 = $urandom; br_rs2 = $urandom; br_pc = $urandom; br_imm = $urandom;
   endtask
   // One full branch: optional stalled idle cycle, accept, EVAL stalls, redirect, flush window.
   task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input int stalls, input bit fstall, input bit istall);
      logic t, ill;
      t   = ref_taken(f3, a, b);
      ill = (f3 == 3'd2 || f3 == 3'd3);
      if (istall) begin
         stall_in = 1; drive_req(f3, a, b, pc, imm);
         #1 check("ready_in_stall", br_ready, 0);
         @(negedge clk);
         stall_in = 0;
      end
      drive_req(f3, a, b, pc, imm);
      #1 check("ready_idle", br_ready, 1);
      @(negedge clk);
      scramble_inputs();
      for (int s = 0; s < stalls; s++) begin
         stall_in = 1;
         #1 check("stall_redirect", redirect_valid, 0);
         check("stall_illegal", illegal_br, 0);
         check("stall_flush", flush, 0);
         @(negedge clk);
      end
      stall_in = 0;
      #1 check("redirect_valid", redirect_valid, t);
      check("illegal_br", illegal_br, ill);
      check("flush_eval", flush, t);
      check("ready_eval", br_ready, 0);
      if (t) check("redirect_pc", redirect_pc, 32'(pc + imm));
      m_br++;
      if (t) m_tk++;
      @(negedge clk);
      if (t) for (int i = 0; i < FC - 1; i++) begin
         if (fstall && i == 0) begin
            stall_in = 1;
            #1 check("flush_stalled", flush, 1);
            check("ready_flush_stalled", br_ready, 0);
            @(negedge clk);
            stall_in = 0;
         end
         #1 check("flush_hold", flush, 1);
         check("redirect_once", redirect_valid, 0);
         check("illegal_flush", illegal_br, 0);
         @(negedge clk);
      end
      br_valid = 0;
      #1 check("flush_done", flush, 0);
      check("ready_back", br_ready, 1);
      check("no_redirect_idle", redirect_valid, 0);
      check_stats("post_branch");
   endtask
   task automatic reset_in_flush();
      drive_req(3'd0, 32'd7, 32'd7, 32'h200, 32'h40);
      @(negedge clk);
      scramble_inputs();
      #1 check("rf_redirect", redirect_valid, 1);
      @(negedge clk);
      br_valid = 0; rst = 1;
      #1 check("rf_flush_before", flush, 1);
      @(negedge clk);
      rst = 0;
      m_br = 0; m_tk = 0;
      #1 check("rf_flush_cleared", flush, 0);
      check("rf_ready", br_ready, 1);
      check("rf_redirect_after", redirect_valid, 0);
      check_stats("rf");
   endtask
   task automatic reset_in_eval();
      drive_req(3'd1, 32'd1, 32'd2, 32'h300, 32'h10);
      @(negedge clk);
      br_valid = 0; rst = 1;
      #1 check("re_redirect_suppressed", redirect_valid, 0);
      @(negedge clk);
      rst = 0;
      m_br = 0; m_tk = 0;
      #1 check("re_flush", flush, 0);
      check("re_ready", br_ready, 1);
      @(negedge clk);
      #1 check("re_no_late_redirect", redirect_valid, 0);
      check_stats("re");
   endtask
   initial begin
      #2000000 $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] a, b;
      rst = 1; stall_in = 0; br_valid = 0; br_funct3 = 0;
      br_rs1 = 0; br_rs2 = 0; br_pc = 0; br_imm = 0;
      repeat (2) @(negedge clk);
      #1 check("rst_redirect_pc", redirect_pc, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_illegal", illegal_br, 0);
      check_stats("rst");
      rst = 0;
      #1 check("rst_ready", br_ready, 1);
      @(negedge clk);
      branch(3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 0, 0, 0);
      branch(3'd4, 32'hFFFFFFFF, 32'h1, 32'h400, 32'h8, 0, 0, 0);
      branch(3'd6, 32'hFFFFFFFF, 32'h1, 32'h400, 32'h8, 0, 0, 0);
      branch(3'd2, 32'h3, 32'h3, 32'h500, 32'h4, 0, 0, 0);
      branch(3'd3, 32'h1, 32'h9, 32'h500, 32'h4, 1, 0, 0);
      branch(3'd1, 32'h1, 32'h2, 32'h600, 32'hFFFFFFF0, 3, 0, 0);
      branch(3'd5, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h4, 0, 0, 0);
      branch(3'd7, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF0, 32'h20, 0, 1, 1);
      reset_in_flush();
      reset_in_eval();
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ 32'h80000000;
            2: b = a + 32'(int'($urandom_range(0, 2)) - 1);
            default: b = $urandom;
         endcase
         branch(3'($urandom_range(0, 7)), a, b, $urandom, $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
